avr_dmem: RTL and testbench

- Data-space responder for the AVR core; sits at the far end of the core's data bus (d_addr, bidirectional data, data_write).
- Services the core's PUSH/POP-style accesses: writes on the issue cycle, read data driven onto the bus one cycle later.
- Contains a byte-wide SRAM window and a loader/clear FSM that preloads or zeroes memory from the testbench/host side while holding the core off with a stall.

---
 rtl/avr_pkg.sv | 16 +
 rtl/avr_sram_1p.sv | 25 ++
 rtl/avr_dmem.sv | 139 +++++++++++++
 tb/tb_avr_dmem.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/avr_pkg.sv
// Shared AVR data-space definitions: loader FSM encoding and address map.
package avr_pkg;

    // Data-memory responder FSM states
    typedef enum logic [1:0] {
        DM_IDLE  = 2'd0,
        DM_LOAD  = 2'd1,
        DM_CLEAR = 2'd2
    } dm_state_e;

    // Data-space map; the core's SP/IO decode uses the same constants
    localparam logic [15:0] REG_BASE  = 16'h0000;
    localparam logic [15:0] IO_BASE   = 16'h0020;
    localparam logic [15:0] DMEM_BASE = 16'h0060;

endpackage

// File: rtl/avr_sram_1p.sv
// Single-port byte SRAM: synchronous write, registered read output.
module avr_sram_1p #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_q;

    // Storage and read register; neither is reset
    always_ff @(posedge clk) begin
        if (en && we)  mem_q[addr] <= wdata;
        if (en && !we) rdata_q     <= mem_q[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/avr_dmem.sv
// AVR data-space SRAM responder with host-side load/clear FSM.
module avr_dmem
    import avr_pkg::*;
#(
    parameter int          DEPTH = 1024,
    parameter int          AW    = 10,
    parameter logic [15:0] BASE  = DMEM_BASE
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] d_addr,
    inout  logic [7:0]  data,
    input  logic        data_write,
    input  logic        d_en,
    output logic        mem_stall,
    output logic        acc_err,
    input  logic        ld_start,
    input  logic [15:0] ld_base,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    input  logic        clr_start
);

    localparam logic [15:0] DEPTH16 = 16'(DEPTH);

    dm_state_e     state_q, state_d;
    logic [15:0]   lp_q, lp_d;
    logic [AW-1:0] cp_q, cp_d;
    logic          rd_pend_q, rd_pend_d;
    logic          rd_oow_q, rd_oow_d;
    logic          acc_err_q, acc_err_d;

    logic [15:0]   core_off, ld_off;
    logic          core_in_win, ld_in_win;
    logic [7:0]    data_in, rdata;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_wdata;
    logic          rd_drive;

    // Window checks done in 16-bit arithmetic so addresses below BASE wrap high
    assign core_off    = d_addr - BASE;
    assign core_in_win = (d_addr >= BASE) && (core_off < DEPTH16);
    assign ld_off      = lp_q - BASE;
    assign ld_in_win   = (lp_q >= BASE) && (ld_off < DEPTH16);

    assign data_in   = data;
    assign mem_stall = (state_q != DM_IDLE);
    assign ld_ready  = (state_q == DM_LOAD);
    assign acc_err   = acc_err_q;

    // Read return owns the bus for one cycle unless the core is writing then
    assign rd_drive = rd_pend_q && !data_write;
    assign data     = rd_drive ? (rd_oow_q ? 8'h00 : rdata) : 8'hzz;

    // Next-state, SRAM port mux and error/read-return bookkeeping
    always_comb begin
        state_d   = state_q;
        lp_d      = lp_q;
        cp_d      = cp_q;
        rd_pend_d = 1'b0;
        rd_oow_d  = 1'b0;
        acc_err_d = 1'b0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = core_off[AW-1:0];
        ram_wdata = data_in;
        case (state_q)
            DM_IDLE: begin
                if (d_en) begin
                    ram_en    = core_in_win;
                    ram_we    = data_write;
                    acc_err_d = !core_in_win;
                    rd_pend_d = !data_write;
                    rd_oow_d  = !data_write && !core_in_win;
                end
                // Clear takes priority over a simultaneous load request
                if (clr_start) begin
                    state_d = DM_CLEAR;
                    cp_d    = '0;
                end else if (ld_start) begin
                    state_d = DM_LOAD;
                    lp_d    = ld_base;
                end
            end
            DM_LOAD: begin
                if (ld_valid) begin
                    ram_en    = ld_in_win;
                    ram_we    = 1'b1;
                    ram_addr  = ld_off[AW-1:0];
                    ram_wdata = ld_data;
                    acc_err_d = !ld_in_win;
                    lp_d      = lp_q + 16'd1;
                    if (ld_last) state_d = DM_IDLE;
                end
            end
            DM_CLEAR: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = cp_q;
                ram_wdata = 8'h00;
                cp_d      = cp_q + 1'b1;
                if (cp_q == AW'(DEPTH - 1)) state_d = DM_IDLE;
            end
            default: state_d = DM_IDLE;
        endcase
    end

    // State and control registers; SRAM contents survive reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= DM_IDLE;
            lp_q      <= '0;
            cp_q      <= '0;
            rd_pend_q <= 1'b0;
            rd_oow_q  <= 1'b0;
            acc_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lp_q      <= lp_d;
            cp_q      <= cp_d;
            rd_pend_q <= rd_pend_d;
            rd_oow_q  <= rd_oow_d;
            acc_err_q <= acc_err_d;
        end
    end

    avr_sram_1p #(.DEPTH(DEPTH), .AW(AW)) u_sram (
        .clk   (CLK),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_avr_dmem.sv
// Self-checking bench for avr_dmem: vector table, load/clear/reset sequences, random core traffic.
module tb_avr_dmem;

    logic        CLK, RST;
    logic [15:0] d_addr, ld_base;
    logic        data_write, d_en, ld_start, ld_valid, ld_last, clr_start;
    logic [7:0]  ld_data, core_wdata;
    logic        mem_stall, acc_err, ld_ready;
    tri1  [7:0]  data;

    // Core side drives the bus only when writing; a released bus floats high
    assign data = data_write ? core_wdata : 8'hzz;

    avr_dmem dut (
        .CLK(CLK), .RST(RST), .d_addr(d_addr), .data(data), .data_write(data_write),
        .d_en(d_en), .mem_stall(mem_stall), .acc_err(acc_err), .ld_start(ld_start),
        .ld_base(ld_base), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ld_ready), .clr_start(clr_start)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h", nm, act, exp);
    endtask

    task automatic idle_in();
        d_en = 0; data_write = 0; d_addr = 16'h0; core_wdata = 8'h0;
        ld_start = 0; ld_base = 16'h0; ld_valid = 0; ld_data = 8'h0; ld_last = 0; clr_start = 0;
    endtask

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    // Issue a read, then check the value returned on the bus the following cycle
    task automatic read_chk(input logic [15:0] a, input logic [7:0] exp, input string nm);
        idle_in(); d_en = 1; d_addr = a;
        tick();
        idle_in();
        @(negedge CLK);
        chk(nm, {24'h0, data}, {24'h0, exp});
        tick();
    endtask

    typedef struct {
        logic        en;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wd;
        logic [7:0]  exp_bus;
        logic        exp_err;
    } vec_t;

    vec_t tbl[17];

    logic [7:0] mdl [1024];

    initial begin
        int cnt;
        logic seen;
        logic prev_rd, prev_err, in_w;
        logic [7:0] prev_val, exp_bus;
        int off;

        idle_in();
        RST = 1;
        tick(); tick();
        @(negedge CLK);
        chk("rst_stall", {31'h0, mem_stall}, 0);
        chk("rst_ready", {31'h0, ld_ready}, 0);
        chk("rst_err",   {31'h0, acc_err}, 0);
        chk("rst_bus",   {24'h0, data}, 32'hFF);
        tick();
        RST = 0;

        // bus column is the value seen in that cycle (core write data, read return, or released FF)
        tbl[0]  = '{1, 1, 16'h0060, 8'hA5, 8'hA5, 0};
        tbl[1]  = '{1, 0, 16'h0060, 8'h00, 8'hFF, 0};
        tbl[2]  = '{0, 0, 16'h0000, 8'h00, 8'hA5, 0};
        tbl[3]  = '{0, 0, 16'h0000, 8'h00, 8'hFF, 0};
        tbl[4]  = '{1, 0, 16'h0010, 8'h00, 8'hFF, 0};
        tbl[5]  = '{1, 1, 16'h0460, 8'h5A, 8'h5A, 1};
        tbl[6]  = '{0, 0, 16'h0000, 8'h00, 8'hFF, 1};
        tbl[7]  = '{1, 1, 16'h045F, 8'h77, 8'h77, 0};
        tbl[8]  = '{1, 0, 16'h045F, 8'h00, 8'hFF, 0};
        tbl[9]  = '{1, 0, 16'h0060, 8'h00, 8'h77, 0};
        tbl[10] = '{0, 0, 16'h0000, 8'h00, 8'hA5, 0};
        tbl[11] = '{0, 0, 16'h0000, 8'h00, 8'hFF, 0};
        tbl[12] = '{1, 0, 16'h0060, 8'h00, 8'hFF, 0};
        tbl[13] = '{1, 1, 16'h0061, 8'h3C, 8'h3C, 0};
        tbl[14] = '{1, 0, 16'h0061, 8'h00, 8'hFF, 0};
        tbl[15] = '{0, 0, 16'h0000, 8'h00, 8'h3C, 0};
        tbl[16] = '{0, 0, 16'h0000, 8'h00, 8'hFF, 0};
        for (int i = 0; i < 17; i++) begin
            idle_in();
            d_en = tbl[i].en; data_write = tbl[i].en & tbl[i].we;
            d_addr = tbl[i].addr; core_wdata = tbl[i].wd;
            @(negedge CLK);
            chk($sformatf("vec%0d_bus", i), {24'h0, data}, {24'h0, tbl[i].exp_bus});
            chk($sformatf("vec%0d_err", i), {31'h0, acc_err}, {31'h0, tbl[i].exp_err});
            chk($sformatf("vec%0d_stall", i), {31'h0, mem_stall}, 0);
            tick();
        end

        // Load 11/22/33 at 0x0100 with a one-cycle valid gap
        idle_in(); ld_start = 1; ld_base = 16'h0100;
        @(negedge CLK); chk("ld1_start_stall", {31'h0, mem_stall}, 0); tick();
        for (int i = 0; i < 4; i++) begin
            idle_in();
            ld_valid = (i != 1);
            ld_data  = (i == 0) ? 8'h11 : (i == 2) ? 8'h22 : 8'h33;
            ld_last  = (i == 3);
            @(negedge CLK);
            chk($sformatf("ld1_stall%0d", i), {31'h0, mem_stall}, 1);
            chk($sformatf("ld1_ready%0d", i), {31'h0, ld_ready}, 1);
            tick();
        end
        idle_in();
        @(negedge CLK);
        chk("ld1_end_stall", {31'h0, mem_stall}, 0);
        chk("ld1_end_ready", {31'h0, ld_ready}, 0);
        tick();
        read_chk(16'h0100, 8'h11, "ld1_rd0");
        read_chk(16'h0101, 8'h22, "ld1_rd1");
        read_chk(16'h0102, 8'h33, "ld1_rd2");

        // Load across the top of the window: last two bytes dropped
        idle_in(); ld_start = 1; ld_base = 16'h045E; tick();
        for (int i = 0; i < 4; i++) begin
            idle_in();
            ld_valid = 1; ld_data = 8'hAA + 8'(i * 17); ld_last = (i == 3);
            @(negedge CLK);
            chk($sformatf("ld2_err%0d", i), {31'h0, acc_err}, (i == 3) ? 1 : 0);
            tick();
        end
        idle_in();
        @(negedge CLK);
        chk("ld2_end_err", {31'h0, acc_err}, 1);
        chk("ld2_end_stall", {31'h0, mem_stall}, 0);
        tick();
        @(negedge CLK); chk("ld2_err_clear", {31'h0, acc_err}, 0); tick();
        read_chk(16'h045E, 8'hAA, "ld2_rd0");
        read_chk(16'h045F, 8'hBB, "ld2_rd1");
        read_chk(16'h0060, 8'hA5, "ld2_noalias");

        // Clear: count stall cycles; core writes during stall must be lost silently
        idle_in(); clr_start = 1;
        @(negedge CLK); chk("clr_start_stall", {31'h0, mem_stall}, 0); tick();
        cnt = 0; seen = 0;
        while (cnt < 2000) begin
            idle_in();
            if (cnt < 1000) begin
                d_en = 1; data_write = 1; core_wdata = 8'h99;
                d_addr = cnt[0] ? 16'h0010 : 16'h0070;
            end
            @(negedge CLK);
            if (!mem_stall) break;
            cnt++;
            seen = seen | acc_err;
            tick();
        end
        chk("clr_len", cnt, 1024);
        chk("clr_no_err", {31'h0, seen}, 0);
        idle_in(); tick();
        read_chk(16'h0070, 8'h00, "clr_lost_wr");
        read_chk(16'h0100, 8'h00, "clr_rd");

        // Random core traffic against an array model of the now-zeroed window
        for (int i = 0; i < 1024; i++) mdl[i] = 8'h00;
        prev_rd = 0; prev_err = 0; prev_val = 8'h00;
        for (int i = 0; i < 400; i++) begin
            int op;
            idle_in();
            op = $urandom_range(0, 3);
            d_en = (op != 0);
            data_write = (op == 1);
            d_addr = ($urandom_range(0, 4) != 0) ? 16'(32'h60 + $urandom_range(0, 1023)) : 16'($urandom);
            core_wdata = 8'($urandom);
            exp_bus = data_write ? core_wdata : prev_rd ? prev_val : 8'hFF;
            @(negedge CLK);
            chk("rnd_bus", {24'h0, data}, {24'h0, exp_bus});
            chk("rnd_err", {31'h0, acc_err}, {31'h0, prev_err});
            tick();
            off  = int'(d_addr) - 32'h60;
            in_w = (off >= 0) && (off < 1024);
            if (d_en && data_write && in_w) mdl[off] = core_wdata;
            prev_rd  = d_en && !data_write;
            prev_val = (prev_rd && in_w) ? mdl[off] : 8'h00;
            prev_err = d_en && !in_w;
        end

        // Reset in the middle of a load keeps the bytes already written
        idle_in(); ld_start = 1; ld_base = 16'h0200; tick();
        idle_in(); ld_valid = 1; ld_data = 8'h41; tick();
        idle_in(); ld_valid = 1; ld_data = 8'h42; tick();
        idle_in(); RST = 1;
        @(negedge CLK); chk("rstld_pre_stall", {31'h0, mem_stall}, 1); tick();
        RST = 0;
        @(negedge CLK);
        chk("rstld_stall", {31'h0, mem_stall}, 0);
        chk("rstld_ready", {31'h0, ld_ready}, 0);
        chk("rstld_bus", {24'h0, data}, 32'hFF);
        tick();
        read_chk(16'h0200, 8'h41, "rstld_rd0");
        read_chk(16'h0201, 8'h42, "rstld_rd1");

        // Simultaneous load and clear: only the clear runs
        idle_in(); ld_start = 1; clr_start = 1; ld_base = 16'h0300; tick();
        idle_in();
        cnt = 0; seen = 0;
        while (cnt < 2000) begin
            @(negedge CLK);
            if (!mem_stall) break;
            cnt++;
            seen = seen | ld_ready;
            tick();
        end
        chk("both_len", cnt, 1024);
        chk("both_no_ready", {31'h0, seen}, 0);
        tick();
        read_chk(16'h0200, 8'h00, "both_cleared");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
